// File: rtl/multi_head_pp_bridge.sv
// ---------------------------------------------------------------------------
// multi_head_pp_bridge
//   Ping-pong buffer between a linear-projection producer and a systolic
//   matmul. Each accepted beat carries one Q (west) and one K (north) word
//   for every head; all heads move in lockstep through two banks of DEPTH
//   entries. A filled bank is streamed to the matmul REPLAY times before it
//   is handed back to the writer.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   in_valid / in_ready      input beat handshake (in_ready is registered)
//   in_w[h], in_n[h]         per-head Q / K input words
//   acc_done_wrap            matmul accumulation-done pulse
//   systolic_finish_wrap     matmul pass-finished pulse
//   w_dout[h], n_dout[h]     registered read data, valid with out_valid
//   enable_matmul            high while streaming / waiting for finish
//   internal_rst_n_ctrl      low in the first ARM cycle of a bank
//   internal_reset_acc_ctrl  high in ARM and the cycle after acc_done_wrap
//   bank_full[1:0]           per-bank full flags
//   pass_done                one-cycle pulse per completed pass
// ---------------------------------------------------------------------------
module multi_head_pp_bridge #(
  parameter int NUM_HEADS = 4,
  parameter int W_WIDTH   = 256,
  parameter int N_WIDTH   = 256,
  parameter int DEPTH     = 8,
  parameter int REPLAY    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W_WIDTH-1:0] in_w [NUM_HEADS],
  input  logic [N_WIDTH-1:0] in_n [NUM_HEADS],
  input  logic               acc_done_wrap,
  input  logic               systolic_finish_wrap,
  output logic [W_WIDTH-1:0] w_dout [NUM_HEADS],
  output logic [N_WIDTH-1:0] n_dout [NUM_HEADS],
  output logic               out_valid,
  output logic               enable_matmul,
  output logic               internal_rst_n_ctrl,
  output logic               internal_reset_acc_ctrl,
  output logic [1:0]         bank_full,
  output logic               pass_done
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = (REPLAY > 1) ? $clog2(REPLAY) : 1;
  localparam logic [CW-1:0] LAST_CNT    = CW'(DEPTH - 1);
  localparam logic [RW-1:0] LAST_REPLAY = RW'(REPLAY - 1);

  typedef enum logic [1:0] {IDLE, ARM, STREAM, WAIT_FIN} state_t;

  state_t         state;
  logic           wr_bank;
  logic [CW-1:0]  wr_cnt;
  logic           rd_bank;
  logic [CW-1:0]  rd_cnt;
  logic [RW-1:0]  replay_cnt;

  logic [W_WIDTH-1:0] mem_w [2][DEPTH][NUM_HEADS];
  logic [N_WIDTH-1:0] mem_n [2][DEPTH][NUM_HEADS];

  logic       accept;
  logic       fill_done;
  logic       release_bank;
  logic [1:0] set_mask;
  logic [1:0] clr_mask;
  logic [1:0] bank_full_nx;
  logic       wr_bank_nx;

  // Fill and release of opposite banks may coincide; both masks apply.
  always_comb begin
    accept       = in_valid & in_ready;
    fill_done    = accept && (wr_cnt == LAST_CNT);
    release_bank = (state == WAIT_FIN) && systolic_finish_wrap &&
                   (replay_cnt == LAST_REPLAY);
    set_mask     = fill_done    ? (2'b01 << wr_bank) : 2'b00;
    clr_mask     = release_bank ? (2'b01 << rd_bank) : 2'b00;
    bank_full_nx = (bank_full | set_mask) & ~clr_mask;
    wr_bank_nx   = wr_bank ^ fill_done;
  end

  // Write side. in_ready looks ahead at the next flags and bank so that a
  // beat can never land in a bank that is becoming full at this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      bank_full <= 2'b00;
      in_ready  <= 1'b0;
    end else begin
      bank_full <= bank_full_nx;
      wr_bank   <= wr_bank_nx;
      if (accept)
        wr_cnt <= fill_done ? '0 : wr_cnt + 1'b1;
      in_ready  <= ~bank_full_nx[wr_bank_nx];
    end
  end

  // Storage is not reset; validity is carried entirely by bank_full.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      for (int unsigned h = 0; h < NUM_HEADS; h++) begin
        mem_w[wr_bank][wr_cnt][h] <= in_w[h];
        mem_n[wr_bank][wr_cnt][h] <= in_n[h];
      end
    end
  end

  // Read FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                   <= IDLE;
      rd_bank                 <= 1'b0;
      rd_cnt                  <= '0;
      replay_cnt              <= '0;
      out_valid               <= 1'b0;
      enable_matmul           <= 1'b0;
      internal_rst_n_ctrl     <= 1'b0;
      internal_reset_acc_ctrl <= 1'b0;
      pass_done               <= 1'b0;
      w_dout                  <= '{default: '0};
      n_dout                  <= '{default: '0};
    end else begin
      out_valid               <= 1'b0;
      pass_done               <= 1'b0;
      internal_rst_n_ctrl     <= 1'b1;
      internal_reset_acc_ctrl <= acc_done_wrap;
      case (state)
        IDLE: begin
          enable_matmul <= 1'b0;
          if (bank_full[rd_bank]) begin
            state                   <= ARM;
            internal_rst_n_ctrl     <= (replay_cnt != '0);
            internal_reset_acc_ctrl <= 1'b1;
          end
        end
        ARM: begin
          state         <= STREAM;
          rd_cnt        <= '0;
          enable_matmul <= 1'b1;
        end
        STREAM: begin
          enable_matmul <= 1'b1;
          out_valid     <= 1'b1;
          for (int unsigned h = 0; h < NUM_HEADS; h++) begin
            w_dout[h] <= mem_w[rd_bank][rd_cnt][h];
            n_dout[h] <= mem_n[rd_bank][rd_cnt][h];
          end
          if (rd_cnt == LAST_CNT)
            state <= WAIT_FIN;
          else
            rd_cnt <= rd_cnt + 1'b1;
        end
        WAIT_FIN: begin
          if (systolic_finish_wrap) begin
            pass_done     <= 1'b1;
            enable_matmul <= 1'b0;
            if (replay_cnt == LAST_REPLAY) begin
              replay_cnt <= '0;
              rd_bank    <= ~rd_bank;
              state      <= IDLE;
            end else begin
              // Replays re-arm without clearing the matmul (replay_cnt != 0).
              replay_cnt              <= replay_cnt + 1'b1;
              state                   <= ARM;
              internal_reset_acc_ctrl <= 1'b1;
            end
          end else begin
            enable_matmul <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          enable_matmul <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_head_pp_bridge.sv
module tb_multi_head_pp_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, fin1, fin3, acc;
  logic [7:0] in_w [2];
  logic [7:0] in_n [2];

  logic       rdy1, ov1, en1, rstn1, racc1, pd1;
  logic [1:0] bf1;
  logic [7:0] w1 [2];
  logic [7:0] n1 [2];
  logic       rdy3, ov3, en3, rstn3, racc3, pd3;
  logic [1:0] bf3;
  logic [7:0] w3 [2];
  logic [7:0] n3 [2];

  multi_head_pp_bridge #(.NUM_HEADS(2), .W_WIDTH(8), .N_WIDTH(8),
                         .DEPTH(4), .REPLAY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_w(in_w), .in_n(in_n), .acc_done_wrap(acc),
    .systolic_finish_wrap(fin1), .w_dout(w1), .n_dout(n1),
    .out_valid(ov1), .enable_matmul(en1), .internal_rst_n_ctrl(rstn1),
    .internal_reset_acc_ctrl(racc1), .bank_full(bf1), .pass_done(pd1));

  multi_head_pp_bridge #(.NUM_HEADS(2), .W_WIDTH(8), .N_WIDTH(8),
                         .DEPTH(4), .REPLAY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3),
    .in_w(in_w), .in_n(in_n), .acc_done_wrap(acc),
    .systolic_finish_wrap(fin3), .w_dout(w3), .n_dout(n3),
    .out_valid(ov3), .enable_matmul(en3), .internal_rst_n_ctrl(rstn3),
    .internal_reset_acc_ctrl(racc3), .bank_full(bf3), .pass_done(pd3));

  // Observed DUT selected by sel (0: REPLAY=1, 1: REPLAY=3).
  logic       sel;
  logic       o_rdy, o_ov, o_en, o_rstn, o_racc, o_pd;
  logic [1:0] o_bf;
  logic [7:0] o_w0, o_w1, o_n0, o_n1;
  always_comb begin
    o_rdy  = sel ? rdy3  : rdy1;
    o_ov   = sel ? ov3   : ov1;
    o_en   = sel ? en3   : en1;
    o_rstn = sel ? rstn3 : rstn1;
    o_racc = sel ? racc3 : racc1;
    o_pd   = sel ? pd3   : pd1;
    o_bf   = sel ? bf3   : bf1;
    o_w0   = sel ? w3[0] : w1[0];
    o_w1   = sel ? w3[1] : w1[1];
    o_n0   = sel ? n3[0] : n1[0];
    o_n1   = sel ? n3[1] : n1[1];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [7:0] v);
    in_w[0] = v;
    in_w[1] = v + 8'd10;
    in_n[0] = v ^ 8'h80;
    in_n[1] = (v + 8'd10) ^ 8'h80;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; fin1 = 1'b0; fin3 = 1'b0; acc = 1'b0;
    set_beat(8'd0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic fill(input logic [7:0] first);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fill_ready", o_rdy, 1);
      set_beat(first + 8'(i));
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid and checks one DEPTH-long burst.
  task automatic burst(input logic [7:0] first);
    int cnt = 0;
    while (o_ov !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("burst_start", o_ov, 1);
    for (int i = 0; i < 4; i++) begin
      chk("burst_valid", o_ov, 1);
      chk("burst_w0", o_w0, first + 8'(i));
      chk("burst_w1", o_w1, first + 8'(i) + 8'd10);
      chk("burst_n0", o_n0, (first + 8'(i)) ^ 8'h80);
      chk("burst_n1", o_n1, (first + 8'(i) + 8'd10) ^ 8'h80);
      tick();
    end
    chk("burst_end_valid", o_ov, 0);
    chk("burst_end_en", o_en, 1);
  endtask

  typedef struct {
    logic       rst, iv;
    logic [7:0] bv;
    logic       fin, acc;
    logic       e_rdy, e_ov, e_en, e_rstn, e_racc, e_pd;
    logic [1:0] e_bf;
    logic [7:0] e_w0, e_w1;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  function automatic vec_t mk(logic rst, logic iv, logic [7:0] bv, logic fin, logic a,
                              logic rdy, logic ov, logic en, logic rstn, logic racc,
                              logic pd, logic [1:0] bf, logic [7:0] w0, logic [7:0] w1);
    vec_t v;
    v.rst = rst; v.iv = iv; v.bv = bv; v.fin = fin; v.acc = a;
    v.e_rdy = rdy; v.e_ov = ov; v.e_en = en; v.e_rstn = rstn; v.e_racc = racc;
    v.e_pd = pd; v.e_bf = bf; v.e_w0 = w0; v.e_w1 = w1;
    return v;
  endfunction

  task automatic run_table(input int start);
    for (int i = start; i < NV; i++) begin
      rst_n = tbl[i].rst; in_valid = tbl[i].iv; set_beat(tbl[i].bv);
      fin1 = tbl[i].fin; acc = tbl[i].acc;
      tick();
      chk($sformatf("row%0d_ready", i), o_rdy, tbl[i].e_rdy);
      chk($sformatf("row%0d_valid", i), o_ov, tbl[i].e_ov);
      chk($sformatf("row%0d_en", i), o_en, tbl[i].e_en);
      chk($sformatf("row%0d_rstn", i), o_rstn, tbl[i].e_rstn);
      chk($sformatf("row%0d_racc", i), o_racc, tbl[i].e_racc);
      chk($sformatf("row%0d_pd", i), o_pd, tbl[i].e_pd);
      chk($sformatf("row%0d_bf", i), o_bf, tbl[i].e_bf);
      chk($sformatf("row%0d_w0", i), o_w0, tbl[i].e_w0);
      chk($sformatf("row%0d_w1", i), o_w1, tbl[i].e_w1);
      chk($sformatf("row%0d_n0", i), o_n0, (tbl[i].e_w0 == 8'd0) ? 8'd0 : (tbl[i].e_w0 ^ 8'h80));
    end
    fin1 = 1'b0; acc = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    int   acc_cnt, guard;
    logic rdy_s;
    logic [7:0] nxt;

    //              rst iv bv fin acc | rdy ov en rstn racc pd bf  w0 w1
    tbl[0]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 2'b00, 0, 0);
    tbl[2]  = mk(1, 1, 1, 0, 0,  1, 0, 0, 1, 0, 0, 2'b00, 0, 0);
    tbl[3]  = mk(1, 1, 2, 0, 0,  1, 0, 0, 1, 0, 0, 2'b00, 0, 0);
    tbl[4]  = mk(1, 1, 3, 0, 0,  1, 0, 0, 1, 0, 0, 2'b00, 0, 0);
    tbl[5]  = mk(1, 1, 4, 0, 0,  1, 0, 0, 1, 0, 0, 2'b01, 0, 0);   // edge E
    tbl[6]  = mk(1, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 2'b01, 0, 0);   // ARM
    tbl[7]  = mk(1, 0, 0, 0, 0,  1, 0, 1, 1, 0, 0, 2'b01, 0, 0);   // STREAM
    tbl[8]  = mk(1, 0, 0, 0, 0,  1, 1, 1, 1, 0, 0, 2'b01, 1, 11);  // E+3
    tbl[9]  = mk(1, 0, 0, 0, 1,  1, 1, 1, 1, 1, 0, 2'b01, 2, 12);  // acc in STREAM
    tbl[10] = mk(1, 0, 0, 1, 0,  1, 1, 1, 1, 0, 0, 2'b01, 3, 13);  // finish in STREAM
    tbl[11] = mk(1, 0, 0, 0, 0,  1, 1, 1, 1, 0, 0, 2'b01, 4, 14);
    tbl[12] = mk(1, 0, 0, 0, 0,  1, 0, 1, 1, 0, 0, 2'b01, 4, 14);  // WAIT_FIN
    tbl[13] = mk(1, 0, 0, 1, 0,  1, 0, 0, 1, 0, 1, 2'b00, 4, 14);  // release
    tbl[14] = mk(1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 2'b00, 4, 14);
    tbl[15] = mk(1, 0, 0, 0, 1,  1, 0, 0, 1, 1, 0, 2'b00, 4, 14);  // acc in IDLE
    tbl[16] = mk(1, 0, 0, 1, 0,  1, 0, 0, 1, 0, 0, 2'b00, 4, 14);  // finish in IDLE

    sel = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; fin1 = 1'b0; fin3 = 1'b0; acc = 1'b0;
    set_beat(8'd0);

    // Reset, basic fill/stream, acc_done and stray finish pulses.
    run_table(0);

    // Backpressure: 12 continuous beats, finish withheld.
    do_reset();
    in_valid = 1'b1; nxt = 8'd1; set_beat(nxt); acc_cnt = 0; guard = 0;
    while (acc_cnt < 8 && guard < 40) begin
      rdy_s = o_rdy;
      tick();
      guard++;
      if (rdy_s) begin
        acc_cnt++;
        nxt = nxt + 8'd1;
        set_beat(nxt);
      end
    end
    chk("bp_accepted", acc_cnt, 8);
    chk("bp_ready_low", o_rdy, 0);
    chk("bp_bf_both", o_bf, 2'b11);
    for (int i = 0; i < 10; i++) begin
      rdy_s = o_rdy;
      tick();
      if (rdy_s) acc_cnt++;
    end
    chk("bp_held", acc_cnt, 8);
    chk("bp_bf_hold", o_bf, 2'b11);
    in_valid = 1'b0; fin1 = 1'b1;
    tick();
    fin1 = 1'b0;
    chk("bp_release_pd", o_pd, 1);
    chk("bp_release_bf", o_bf, 2'b10);
    chk("bp_release_rdy", o_rdy, 1);
    burst(8'd5);
    fill(8'd9);
    chk("bp_refill_bf", o_bf, 2'b11);
    fin1 = 1'b1;
    tick();
    fin1 = 1'b0;
    chk("bp_bank1_release", o_bf, 2'b01);
    burst(8'd9);

    // Fill of bank1 completes at the same edge bank0 is released.
    do_reset();
    fill(8'd1);
    burst(8'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_beat(8'd5 + 8'(i));
      tick();
    end
    set_beat(8'd8); fin1 = 1'b1;
    tick();
    fin1 = 1'b0; in_valid = 1'b0;
    chk("sim_bf", o_bf, 2'b10);
    chk("sim_rdy", o_rdy, 1);
    chk("sim_pd", o_pd, 1);
    tick();
    chk("sim_pd_pulse", o_pd, 0);

    // Reset in the middle of a stream, then a fresh run of the table.
    do_reset();
    fill(8'd1);
    guard = 0;
    while (o_ov !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    chk("mid_stream_seen", o_ov, 1);
    tick();
    tick();
    chk("mid_stream_entry2", o_w0, 8'd3);
    rst_n = 1'b0;
    tick();
    chk("mrst_ready", o_rdy, 0);
    chk("mrst_valid", o_ov, 0);
    chk("mrst_en", o_en, 0);
    chk("mrst_rstn", o_rstn, 0);
    chk("mrst_racc", o_racc, 0);
    chk("mrst_pd", o_pd, 0);
    chk("mrst_bf", o_bf, 2'b00);
    chk("mrst_w0", o_w0, 8'd0);
    chk("mrst_n1", o_n1, 8'd0);
    run_table(1);

    // Replayed bank (REPLAY=3).
    sel = 1'b1;
    do_reset();
    fill(8'd1);
    for (int p = 0; p < 3; p++) begin
      guard = 0;
      while (!(o_en === 1'b0 && o_racc === 1'b1) && guard < 10) begin
        tick();
        guard++;
      end
      chk($sformatf("rep%0d_arm", p), o_racc, 1);
      chk($sformatf("rep%0d_rstn", p), o_rstn, (p == 0) ? 0 : 1);
      burst(8'd1);
      tick();
      chk($sformatf("rep%0d_wait_en", p), o_en, 1);
      chk($sformatf("rep%0d_wait_pd", p), o_pd, 0);
      fin3 = 1'b1;
      tick();
      fin3 = 1'b0;
      chk($sformatf("rep%0d_pd", p), o_pd, 1);
      chk($sformatf("rep%0d_bf", p), o_bf, (p == 2) ? 2'b00 : 2'b01);
    end
    tick();
    chk("rep_idle_pd", o_pd, 0);
    chk("rep_idle_en", o_en, 0);
    chk("rep_idle_rstn", o_rstn, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_head_pp_bridge.md
MULTI_HEAD_PP_BRIDGE -- requirements
Module: multi_head_pp_bridge

Interface
REQ-001 SHALL have parameter NUM_HEADS, default 4: independent Q/K head channels buffered in lockstep.
REQ-002 SHALL have parameter W_WIDTH, default 256: west (Q) word width per head.
REQ-003 SHALL have parameter N_WIDTH, default 256: north (K) word width per head.
REQ-004 SHALL have parameter DEPTH, default 8, min 2: entries per bank per head.
REQ-005 SHALL have parameter REPLAY, default 1, min 1: read passes per filled bank before release.
REQ-006 SHALL have port clk  in  1: single clock, all logic rising-edge.
REQ-007 SHALL have port rst_n  in  1: reset, synchronous, active-low.
REQ-008 SHALL have port in_valid  in  1: linear-projection beat valid.
REQ-009 SHALL have port in_ready  out  1: beat accepted when in_valid && in_ready.
REQ-010 SHALL have port in_w  in  W_WIDTH x [NUM_HEADS]: Q words.
REQ-011 SHALL have port in_n  in  N_WIDTH x [NUM_HEADS]: K words.
REQ-012 SHALL have port acc_done_wrap  in  1: matmul accumulation-done pulse.
REQ-013 SHALL have port systolic_finish_wrap  in  1: matmul pass-finished pulse.
REQ-014 SHALL have port w_dout  out  W_WIDTH x [NUM_HEADS], and port n_dout  out  N_WIDTH x [NUM_HEADS]: registered read data.
REQ-015 SHALL have port out_valid  out  1: w_dout/n_dout valid.
REQ-016 SHALL have ports enable_matmul, internal_rst_n_ctrl, internal_reset_acc_ctrl  out  1 each: matmul control.
REQ-017 SHALL have ports bank_full  out  2 (per-bank full flag) and pass_done  out  1 (one-cycle pulse per completed pass).

Function
REQ-018 SHALL hold two banks, each DEPTH x NUM_HEADS entries of W_WIDTH+N_WIDTH bits; all heads share one write pointer and one read pointer.
REQ-019 Write side SHALL use wr_bank and wr_cnt; in_ready = !bank_full[wr_bank], registered from the flags, so it changes only on clock edges.
REQ-020 Each accepted beat SHALL write all heads at wr_cnt of wr_bank and increment wr_cnt; on beat DEPTH-1: wr_cnt<=0, bank_full[wr_bank]<=1, wr_bank toggles.
REQ-021 in_valid while in_ready=0 SHALL be ignored, with no write and no pointer change.
REQ-022 Read FSM SHALL have states IDLE, ARM, STREAM, WAIT_FIN, with rd_bank, rd_cnt and replay_cnt.
REQ-023 In IDLE with bank_full[rd_bank]=1, the FSM SHALL go to ARM; otherwise it stays in IDLE, with enable_matmul=0.
REQ-024 ARM SHALL last one cycle and then go to STREAM with rd_cnt=0.
REQ-025 In ARM, internal_rst_n_ctrl SHALL be 0 only when replay_cnt==0, and internal_reset_acc_ctrl SHALL be 1.
REQ-026 STREAM SHALL drive enable_matmul=1 and read entry rd_cnt each cycle; data and out_valid appear one cycle later. At rd_cnt==DEPTH-1 the FSM SHALL go to WAIT_FIN.
REQ-027 WAIT_FIN SHALL keep enable_matmul=1 and out_valid=0 until systolic_finish_wrap.
REQ-028 On systolic_finish_wrap in WAIT_FIN, pass_done SHALL pulse and then:
  - if replay_cnt==REPLAY-1: bank_full[rd_bank]<=0, rd_bank toggles, replay_cnt<=0, go to IDLE;
  - otherwise: replay_cnt++, go to ARM.
REQ-029 systolic_finish_wrap outside WAIT_FIN SHALL be ignored.
REQ-030 acc_done_wrap SHALL assert internal_reset_acc_ctrl for exactly the following cycle, in any state; this OR-combines with the ARM assertion.
REQ-031 Latency: when the last beat of a bank is accepted at edge E into an idle reader, out_valid SHALL first be high after edge E+3 and stay high for exactly DEPTH consecutive cycles carrying entries 0..DEPTH-1 in order.
REQ-032 When a bank is filled and the other bank is released at the same edge, both flag updates SHALL take effect; in_ready SHALL rise one cycle later.
REQ-033 The writer SHALL never write a bank with bank_full=1, and the reader SHALL never read a bank with bank_full=0.
REQ-034 Outputs not in use SHALL be 0:
  - w_dout and n_dout SHALL hold their last value when out_valid=0;
  - outputs other than internal_rst_n_ctrl SHALL be 0 outside the states named above;
  - internal_rst_n_ctrl SHALL be 1 outside ARM.

Reset
REQ-035 rst_n=0 at an edge SHALL give:
  - FSM=IDLE, wr_bank=rd_bank=0, all counters 0, bank_full=2'b00;
  - in_ready=0 during reset and 1 on the first cycle after release;
  - out_valid=0, enable_matmul=0, internal_reset_acc_ctrl=0, pass_done=0, internal_rst_n_ctrl=0, w_dout=n_dout=0.
REQ-036 Reset mid-fill or mid-stream SHALL discard all buffered data; no pass_done SHALL be emitted for the interrupted bank.

Verification
REQ-037 NUM_HEADS=2, DEPTH=4, REPLAY=1: stream 4 beats, head0 w=1..4 and head1 w=11..14 -> after edge E+3, out_valid high for 4 cycles with head0 {1,2,3,4} and head1 {11,12,13,14}; ARM cycle shows internal_rst_n_ctrl=0.
REQ-038 Continuous in_valid for 12 beats with finish withheld -> in_ready=0 after beat 8, bank_full=2'b11; pulse systolic_finish_wrap -> bank0 released and beats 9-12 accepted into bank0.
REQ-039 REPLAY=3: one filled bank, finish pulsed 3 times -> 3 STREAM bursts of identical data; internal_rst_n_ctrl low only in the first ARM; 3 pass_done pulses; bank released after the third.
REQ-040 acc_done_wrap pulsed during STREAM and during IDLE -> internal_reset_acc_ctrl high exactly the next cycle each time; stream data unaffected.
REQ-041 rst_n low for 1 cycle at stream entry 2 -> all outputs at reset values, bank_full=0; a fresh 4-beat fill then reproduces REQ-037 exactly.
REQ-042 systolic_finish_wrap in IDLE and in STREAM -> no state change and no pass_done; the same cycle that completes bank1 fill and releases bank0 -> bank_full=2'b10 and in_ready=1 the next cycle.
